// File: rtl/axi_lite_banked_memory_if.sv
// AXI4-Lite bus bundle for the banked scratch memory.
interface axi_lite_banked_memory_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   S_AXIL_AWADDR;
   logic                    S_AXIL_AWVALID;
   logic                    S_AXIL_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXIL_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXIL_WSTRB;
   logic                    S_AXIL_WVALID;
   logic                    S_AXIL_WREADY;
   logic [1:0]              S_AXIL_BRESP;
   logic                    S_AXIL_BVALID;
   logic                    S_AXIL_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXIL_ARADDR;
   logic                    S_AXIL_ARVALID;
   logic                    S_AXIL_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXIL_RDATA;
   logic [1:0]              S_AXIL_RRESP;
   logic                    S_AXIL_RVALID;
   logic                    S_AXIL_RREADY;

   modport slave (
      input  S_AXIL_AWADDR, S_AXIL_AWVALID, S_AXIL_WDATA, S_AXIL_WSTRB, S_AXIL_WVALID,
             S_AXIL_BREADY, S_AXIL_ARADDR, S_AXIL_ARVALID, S_AXIL_RREADY,
      output S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BRESP, S_AXIL_BVALID,
             S_AXIL_ARREADY, S_AXIL_RDATA, S_AXIL_RRESP, S_AXIL_RVALID
   );

   modport master (
      output S_AXIL_AWADDR, S_AXIL_AWVALID, S_AXIL_WDATA, S_AXIL_WSTRB, S_AXIL_WVALID,
             S_AXIL_BREADY, S_AXIL_ARADDR, S_AXIL_ARVALID, S_AXIL_RREADY,
      input  S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BRESP, S_AXIL_BVALID,
             S_AXIL_ARREADY, S_AXIL_RDATA, S_AXIL_RRESP, S_AXIL_RVALID
   );
endinterface

// File: rtl/axi_lite_banked_memory.sv
// AXI4-Lite banked scratch memory: byte-strobe writes, per-bank write
// protection, DECERR/SLVERR responses, independent read and write paths.
module axi_lite_banked_memory #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int NUM_BANKS      = 4,
   parameter int WORDS_PER_BANK = 64,
   parameter logic [NUM_BANKS-1:0] WP_BANK_MASK = '0
) (
   input logic ACLK,
   input logic ARESET,
   axi_lite_banked_memory_if.slave axil
);
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int LSB    = $clog2(NBYTES);
   localparam int OFF    = $clog2(WORDS_PER_BANK);
   localparam int BK     = $clog2(NUM_BANKS);
   localparam int IDX_W  = OFF + BK;
   localparam int DEPTH  = NUM_BANKS * WORDS_PER_BANK;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

   // Bank and offset concatenate into one flat word index {bank,offset}.
   typedef struct packed {
      logic             oor;
      logic [IDX_W-1:0] idx;
   } loc_t;

   typedef struct packed {
      loc_t              loc;
      logic [DATA_WIDTH-1:0] data;
      logic [NBYTES-1:0] strb;
   } wr_req_t;

   typedef enum logic [1:0] {W_ACCEPT, W_COMMIT, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rstate_t;

   function automatic loc_t decode(input logic [ADDR_WIDTH-1:0] addr);
      loc_t l;
      l.oor = |(addr >> (LSB + IDX_W));
      l.idx = IDX_W'(addr >> LSB);
      return l;
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   wstate_t   wstate;
   wr_req_t   wreq;
   logic      aw_held, w_held, awready, wready, bvalid;
   logic [1:0] bresp;
   logic      aw_hs, w_hs, wr_prot, wr_en;
   logic [1:0] commit_resp;

   rstate_t   rstate;
   loc_t      rloc;
   logic      arready, rvalid, ar_hs;
   logic [1:0] rresp;
   logic [DATA_WIDTH-1:0] rdata;

   assign aw_hs   = axil.S_AXIL_AWVALID && awready;
   assign w_hs    = axil.S_AXIL_WVALID && wready;
   assign ar_hs   = axil.S_AXIL_ARVALID && arready;
   assign wr_prot = |(WP_BANK_MASK & (NUM_BANKS'(1) << (wreq.loc.idx >> OFF)));
   assign commit_resp = wreq.loc.oor ? DECERR : (wr_prot ? SLVERR : OKAY);
   assign wr_en   = (wstate == W_COMMIT) && (commit_resp == OKAY);

   assign axil.S_AXIL_AWREADY = awready;
   assign axil.S_AXIL_WREADY  = wready;
   assign axil.S_AXIL_BVALID  = bvalid;
   assign axil.S_AXIL_BRESP   = bresp;
   assign axil.S_AXIL_ARREADY = arready;
   assign axil.S_AXIL_RVALID  = rvalid;
   assign axil.S_AXIL_RRESP   = rresp;
   assign axil.S_AXIL_RDATA   = rdata;

   // Write path: latch AW and W independently, commit for one cycle, hold B.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wstate  <= W_ACCEPT;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         awready <= 1'b0;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= OKAY;
         wreq    <= '0;
      end else begin
         case (wstate)
            W_ACCEPT: begin
               if (aw_hs) begin
                  wreq.loc <= decode(axil.S_AXIL_AWADDR);
                  aw_held  <= 1'b1;
               end
               if (w_hs) begin
                  wreq.data <= axil.S_AXIL_WDATA;
                  wreq.strb <= axil.S_AXIL_WSTRB;
                  w_held    <= 1'b1;
               end
               if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                  awready <= 1'b0;
                  wready  <= 1'b0;
                  wstate  <= W_COMMIT;
               end else begin
                  awready <= !(aw_held || aw_hs);
                  wready  <= !(w_held || w_hs);
               end
            end
            W_COMMIT: begin
               bresp  <= commit_resp;
               bvalid <= 1'b1;
               wstate <= W_RESP;
            end
            W_RESP: begin
               if (axil.S_AXIL_BREADY) begin
                  bvalid  <= 1'b0;
                  bresp   <= OKAY;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  awready <= 1'b1;
                  wready  <= 1'b1;
                  wstate  <= W_ACCEPT;
               end
            end
            default: wstate <= W_ACCEPT;
         endcase
      end
   end

   // Byte-lane write; a commit cycle that coincides with reset is dropped.
   always_ff @(posedge ACLK) begin
      if (wr_en && !ARESET) begin
         for (int i = 0; i < NBYTES; i++)
            if (wreq.strb[i]) mem[wreq.loc.idx][i*8 +: 8] <= wreq.data[i*8 +: 8];
      end
   end

   // Read path: register address, synchronous fetch (read-first), hold R.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rstate  <= R_IDLE;
         rloc    <= '0;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rresp   <= OKAY;
         rdata   <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  rloc    <= decode(axil.S_AXIL_ARADDR);
                  arready <= 1'b0;
                  rstate  <= R_FETCH;
               end else begin
                  arready <= 1'b1;
               end
            end
            R_FETCH: begin
               rdata  <= rloc.oor ? '0 : mem[rloc.idx];
               rresp  <= rloc.oor ? DECERR : OKAY;
               rvalid <= 1'b1;
               rstate <= R_RESP;
            end
            R_RESP: begin
               if (axil.S_AXIL_RREADY) begin
                  rvalid  <= 1'b0;
                  arready <= 1'b1;
                  rstate  <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end
endmodule
